// File: rtl/task_answer_arbiter.sv
// ---------------------------------------------------------------------------
// task_answer_arbiter
//
// Shares the single task-manager answer channel between NUM_TASKS task
// output blocks. One requester is granted at a time and keeps the grant for
// a whole packet. Arbitration is round-robin: the task that finished most
// recently becomes lowest priority. The manager's ready is fanned back to
// the granted task only. Each packet's beat count is checked against the
// size the task advertised when it was granted.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_req              per-task answer-ready request
//   i_tdata            per-task data, task k at [k*DATA_W +: DATA_W]
//   i_last             per-task last-beat flag
//   i_pkt_size         per-task packet size, task k at [k*SIZE_W +: SIZE_W]
//   i_tmanager_ready   manager accepts a beat this cycle
//   o_task_ready       per-task ready, only the granted bit can be set
//   o_tvalid           beat valid toward the manager
//   o_tdata, o_tlast   data / last of the granted task (combinational)
//   o_pkt_size         size latched at grant time
//   o_task_id          index of the granted task
//   o_busy             a packet is in progress
//   o_len_err          one-cycle pulse on a length / protocol error
// ---------------------------------------------------------------------------
module task_answer_arbiter #(
  parameter int NUM_TASKS = 4,
  parameter int DATA_W    = 8,
  parameter int SIZE_W    = 12
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_TASKS-1:0]          i_req,
  input  logic [NUM_TASKS*DATA_W-1:0]   i_tdata,
  input  logic [NUM_TASKS-1:0]          i_last,
  input  logic [NUM_TASKS*SIZE_W-1:0]   i_pkt_size,
  input  logic                          i_tmanager_ready,
  output logic [NUM_TASKS-1:0]          o_task_ready,
  output logic                          o_tvalid,
  output logic [DATA_W-1:0]             o_tdata,
  output logic                          o_tlast,
  output logic [SIZE_W-1:0]             o_pkt_size,
  output logic [$clog2(NUM_TASKS)-1:0]  o_task_id,
  output logic                          o_busy,
  output logic                          o_len_err
);

  localparam int ID_W = $clog2(NUM_TASKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state;
  logic [NUM_TASKS-1:0] sel;
  logic [ID_W-1:0]      grant_id;
  logic [ID_W-1:0]      ptr;
  logic [SIZE_W-1:0]    size_q;
  logic [SIZE_W-1:0]    cnt;
  logic                 busy_q;
  logic                 len_err_q;

  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic [NUM_TASKS-1:0] win_onehot;

  logic                 req_g;
  logic                 last_g;
  logic [DATA_W-1:0]    data_g;
  logic                 zero_size;
  logic                 grant_live;
  logic                 beat;
  logic [SIZE_W-1:0]    cnt_inc;
  logic                 pkt_end;
  logic                 pkt_err;

  // Round-robin search: first requesting task strictly above ptr, wrapping.
  // Starting at ptr+1 and ending at ptr itself means the last served task
  // is only picked again when nobody else is asking.
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    for (int i = 1; i <= NUM_TASKS; i++) begin
      if (!win_found && i_req[(int'(ptr) + i) % NUM_TASKS]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(ptr) + i) % NUM_TASKS);
      end
    end
    win_onehot[win_id] = win_found;
  end

  // Select the granted task's inputs. A zero-size packet never opens the
  // channel, so no beat can slip through before the error exit.
  always_comb begin
    req_g      = i_req[grant_id];
    last_g     = i_last[grant_id];
    data_g     = i_tdata[grant_id*DATA_W +: DATA_W];
    zero_size  = (size_q == '0);
    grant_live = (state == XFER) && !zero_size;
    beat       = grant_live && i_tmanager_ready && req_g;
    cnt_inc    = cnt + 1'b1;
  end

  // Packet termination, checked in priority order. Every exit except a
  // correctly sized last beat is reported as a length/protocol error.
  always_comb begin
    pkt_end = 1'b0;
    pkt_err = 1'b0;
    if (state == XFER) begin
      if (beat && last_g) begin
        pkt_end = 1'b1;
        pkt_err = (cnt_inc != size_q);
      end else if (beat && (cnt_inc == size_q)) begin
        pkt_end = 1'b1;
        pkt_err = 1'b1;
      end else if (!req_g) begin
        pkt_end = 1'b1;
        pkt_err = 1'b1;
      end else if (zero_size) begin
        pkt_end = 1'b1;
        pkt_err = 1'b1;
      end
    end
  end

  // Arbiter FSM. The grant fields are latched on entry to XFER and cleared
  // on entry to GAP, so o_busy falls in the GAP cycle and the error pulse
  // lines up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      grant_id  <= '0;
      ptr       <= ID_W'(NUM_TASKS - 1);
      size_q    <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            sel      <= win_onehot;
            grant_id <= win_id;
            size_q   <= i_pkt_size[win_id*SIZE_W +: SIZE_W];
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            cnt <= cnt_inc;
          end
          if (pkt_end) begin
            len_err_q <= pkt_err;
            sel       <= '0;
            size_q    <= '0;
            busy_q    <= 1'b0;
            ptr       <= grant_id;
            state     <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_task_ready = (grant_live && i_tmanager_ready) ? sel : '0;
  assign o_tvalid     = grant_live && req_g;
  assign o_tdata      = grant_live ? data_g : '0;
  assign o_tlast      = grant_live && last_g;
  assign o_pkt_size   = size_q;
  assign o_task_id    = grant_id;
  assign o_busy       = busy_q;
  assign o_len_err    = len_err_q;

endmodule

// File: tb/tb_task_answer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_task_answer_arbiter
//
// Directed bench for task_answer_arbiter. Each task is driven by a small
// source model (packet length, advertised size, last position, packet
// count). Expected beats are pushed to a scoreboard queue when a packet is
// set up and popped as the arbiter hands beats to the manager.
// ---------------------------------------------------------------------------
module tb_task_answer_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 12;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] tdata;
  logic [N-1:0]    last;
  logic [N*SW-1:0] pkt_size;
  logic            mgr_ready;
  logic [N-1:0]    task_ready;
  logic            tvalid;
  logic [DW-1:0]   odata;
  logic            olast;
  logic [SW-1:0]   opkt;
  logic [1:0]      task_id;
  logic            busy;
  logic            len_err;

  task_answer_arbiter #(.NUM_TASKS(N), .DATA_W(DW), .SIZE_W(SW)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req            (req),
    .i_tdata          (tdata),
    .i_last           (last),
    .i_pkt_size       (pkt_size),
    .i_tmanager_ready (mgr_ready),
    .o_task_ready     (task_ready),
    .o_tvalid         (tvalid),
    .o_tdata          (odata),
    .o_tlast          (olast),
    .o_pkt_size       (opkt),
    .o_task_id        (task_id),
    .o_busy           (busy),
    .o_len_err        (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic          lastFlag;
    int            size;
  } beat_t;

  beat_t expQ[$];
  int    grantIds[$];
  int    grantCycles[$];

  int compared   = 0;
  int mismatched = 0;

  int cycle = 0;
  int errCount = 0;
  int beatCount = 0;
  int tvalidCycles = 0;
  int lastBeatCycle = 0;
  int busyFallCycle = 0;
  int readyCnt[N];
  logic prevBusy = 1'b0;

  int srcLen[N];
  int srcSize[N];
  int srcLastAt[N];
  int srcSent[N];
  int srcPkts[N];
  int srcSerial[N];

  bit toggleMode = 1'b0;
  int phase = 0;

  int errBase;
  int beatBase;

  // Compare one observed value with the bench's own expectation.
  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beatData(input int k, input int serial, input int idx);
    return DW'(k * 64 + serial * 8 + idx);
  endfunction

  task automatic pushPacket(input int k, input int serial, input int nBeats,
                            input int lastAt, input int size);
    for (int i = 0; i < nBeats; i++) begin
      expQ.push_back('{id: k, data: beatData(k, serial, i), lastFlag: (i == lastAt), size: size});
    end
  endtask

  task automatic driveInputs();
    for (int k = 0; k < N; k++) begin
      req[k]                 = (srcPkts[k] > 0);
      tdata[k*DW +: DW]      = beatData(k, srcSerial[k], srcSent[k]);
      last[k]                = (srcSent[k] == srcLastAt[k]);
      pkt_size[k*SW +: SW]   = SW'(srcSize[k]);
    end
  endtask

  task automatic setSource(input int k, input int len, input int size,
                           input int lastAt, input int pkts);
    srcLen[k]    = len;
    srcSize[k]   = size;
    srcLastAt[k] = lastAt;
    srcSent[k]   = 0;
    srcPkts[k]   = pkts;
  endtask

  task automatic finishPkt(input int k);
    srcSent[k] = 0;
    srcSerial[k]++;
    srcPkts[k]--;
  endtask

  task automatic clearStats();
    grantIds.delete();
    grantCycles.delete();
    for (int k = 0; k < N; k++) readyCnt[k] = 0;
    tvalidCycles = 0;
    errBase      = errCount;
    beatBase     = beatCount;
  endtask

  // One clock: observe at the falling edge, then update sources and ready
  // just after the rising edge according to what was accepted.
  task automatic tick();
    logic [N-1:0] acc;
    bit           errSeen;
    int           errId;
    beat_t        e;
    errSeen = 1'b0;
    errId   = -1;
    @(negedge clk);
    checkEq("ready_onehot0", 32'($onehot0(task_ready)), 32'd1);
    for (int k = 0; k < N; k++) if (task_ready[k]) readyCnt[k]++;
    if (tvalid) tvalidCycles++;
    if (tvalid && mgr_ready) begin
      beatCount++;
      lastBeatCycle = cycle;
      compared++;
      assert (expQ.size() > 0) else begin
        mismatched++;
        $error("[TB] FAIL beat_expected: observed beat from task %0d, expected no beat", task_id);
      end
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkEq("beat_id",   32'(task_id), 32'(e.id));
        checkEq("beat_data", 32'(odata),   32'(e.data));
        checkEq("beat_last", 32'(olast),   32'(e.lastFlag));
        checkEq("beat_size", 32'(opkt),    32'(e.size));
      end
    end
    if (len_err) begin
      errCount++;
      errSeen = 1'b1;
      errId   = int'(task_id);
    end
    if (busy && !prevBusy) begin
      grantIds.push_back(int'(task_id));
      grantCycles.push_back(cycle);
    end
    if (!busy && prevBusy) busyFallCycle = cycle;
    prevBusy = busy;
    acc = task_ready & req;
    @(posedge clk);
    #1;
    cycle++;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        srcSent[k]++;
        if (srcSent[k] == srcLen[k]) finishPkt(k);
      end else if (errSeen && errId == k && srcLen[k] == 0 && srcPkts[k] > 0) begin
        finishPkt(k);
      end
    end
    if (toggleMode && busy) begin
      mgr_ready = (phase % 2 == 0);
      phase++;
    end else begin
      mgr_ready = 1'b1;
      phase     = 0;
    end
    driveInputs();
  endtask

  // Run until every source is drained and the arbiter is idle, with a
  // cycle budget; a few extra cycles catch the GAP-cycle error pulse.
  task automatic applyStimulus(input string tag, input int maxCycles);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < maxCycles) begin
      tick();
      n++;
      done = (expQ.size() == 0) && !busy;
      for (int k = 0; k < N; k++) if (srcPkts[k] > 0) done = 1'b0;
    end
    compared++;
    assert (done) else begin
      mismatched++;
      $error("[TB] FAIL %s_timeout: observed %0d cycles without completion, expected under %0d",
             tag, n, maxCycles);
    end
    repeat (3) tick();
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, "_task_ready"}, 32'(task_ready), 32'd0);
    checkEq({tag, "_tvalid"},     32'(tvalid),     32'd0);
    checkEq({tag, "_tdata"},      32'(odata),      32'd0);
    checkEq({tag, "_tlast"},      32'(olast),      32'd0);
    checkEq({tag, "_pkt_size"},   32'(opkt),       32'd0);
    checkEq({tag, "_task_id"},    32'(task_id),    32'd0);
    checkEq({tag, "_busy"},       32'(busy),       32'd0);
    checkEq({tag, "_len_err"},    32'(len_err),    32'd0);
  endtask

  task automatic clearSources();
    for (int k = 0; k < N; k++) begin
      setSource(k, 0, 0, -1, 0);
      srcSerial[k] = 0;
    end
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    clearSources();
    mgr_ready = 1'b1;
    driveInputs();
    #1;
    checkOutput(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prevBusy = 1'b0;
    expQ.delete();
  endtask

  initial begin
    rst_n = 1'b1;
    clearSources();
    mgr_ready = 1'b1;
    driveInputs();
    #2;

    // Power-on reset
    doReset("reset");

    // Single request: task 2, size 3, last on the third beat
    clearStats();
    setSource(2, 3, 3, 2, 1);
    pushPacket(2, srcSerial[2], 3, 2, 3);
    driveInputs();
    applyStimulus("single", 40);
    checkEq("single_grants",    32'(grantIds.size()), 32'd1);
    if (grantIds.size() > 0) checkEq("single_id", 32'(grantIds[0]), 32'd2);
    checkEq("single_ready2",    32'(readyCnt[2]), 32'd3);
    checkEq("single_ready_oth", 32'(readyCnt[0] + readyCnt[1] + readyCnt[3]), 32'd0);
    checkEq("single_tvalid",    32'(tvalidCycles), 32'd3);
    checkEq("single_err",       32'(errCount - errBase), 32'd0);
    checkEq("single_busy_fall", 32'(busyFallCycle - lastBeatCycle), 32'd1);

    // Round-robin among tasks 0, 1 and 3, two packets each of size 2
    doReset("rr_reset");
    clearStats();
    for (int p = 0; p < 2; p++) begin
      pushPacket(0, p, 2, 1, 2);
      pushPacket(1, p, 2, 1, 2);
      pushPacket(3, p, 2, 1, 2);
    end
    setSource(0, 2, 2, 1, 2);
    setSource(1, 2, 2, 1, 2);
    setSource(3, 2, 2, 1, 2);
    driveInputs();
    applyStimulus("rr", 120);
    checkEq("rr_grants", 32'(grantIds.size()), 32'd6);
    for (int i = 0; i < grantIds.size() && i < 6; i++) begin
      int order[3] = '{0, 1, 3};
      checkEq($sformatf("rr_id%0d", i), 32'(grantIds[i]), 32'(order[i % 3]));
      if (i > 0) checkEq($sformatf("rr_spacing%0d", i),
                         32'(grantCycles[i] - grantCycles[i-1]), 32'd4);
    end
    checkEq("rr_err", 32'(errCount - errBase), 32'd0);

    // Backpressure: ready toggles 1,0,1,0 while the packet is open
    clearStats();
    toggleMode = 1'b1;
    setSource(1, 4, 4, 3, 1);
    pushPacket(1, srcSerial[1], 4, 3, 4);
    driveInputs();
    applyStimulus("bp", 60);
    toggleMode = 1'b0;
    checkEq("bp_ready1", 32'(readyCnt[1]), 32'd4);
    checkEq("bp_tvalid", 32'(tvalidCycles), 32'd7);
    checkEq("bp_beats",  32'(beatCount - beatBase), 32'd4);
    checkEq("bp_err",    32'(errCount - errBase), 32'd0);

    // Early last: size 5, last on beat 3
    clearStats();
    setSource(0, 3, 5, 2, 1);
    pushPacket(0, srcSerial[0], 3, 2, 5);
    driveInputs();
    applyStimulus("early_last", 40);
    checkEq("early_last_err",   32'(errCount - errBase), 32'd1);
    checkEq("early_last_beats", 32'(beatCount - beatBase), 32'd3);
    checkEq("early_last_fall",  32'(busyFallCycle - lastBeatCycle), 32'd1);

    // Missing last: size 2, no last flag, force release after beat 2
    clearStats();
    setSource(0, 2, 2, -1, 1);
    pushPacket(0, srcSerial[0], 2, -1, 2);
    driveInputs();
    applyStimulus("no_last", 40);
    checkEq("no_last_err",    32'(errCount - errBase), 32'd1);
    checkEq("no_last_beats",  32'(beatCount - beatBase), 32'd2);
    checkEq("no_last_grants", 32'(grantIds.size()), 32'd1);
    checkEq("no_last_fall",   32'(busyFallCycle - lastBeatCycle), 32'd1);

    // Zero-size packet: error with no beat accepted
    clearStats();
    setSource(3, 0, 0, -1, 1);
    driveInputs();
    applyStimulus("zero", 40);
    checkEq("zero_err",    32'(errCount - errBase), 32'd1);
    checkEq("zero_ready3", 32'(readyCnt[3]), 32'd0);
    checkEq("zero_tvalid", 32'(tvalidCycles), 32'd0);
    checkEq("zero_grants", 32'(grantIds.size()), 32'd1);

    // Withdrawal after 1 of 4 beats
    clearStats();
    setSource(1, 1, 4, -1, 1);
    pushPacket(1, srcSerial[1], 1, -1, 4);
    driveInputs();
    applyStimulus("withdraw", 40);
    checkEq("withdraw_err",    32'(errCount - errBase), 32'd1);
    checkEq("withdraw_beats",  32'(beatCount - beatBase), 32'd1);
    checkEq("withdraw_tvalid", 32'(tvalidCycles), 32'd1);
    checkEq("withdraw_fall",   32'(busyFallCycle - lastBeatCycle), 32'd2);

    // Reset in the middle of a packet, then task 0 must win over task 3
    clearStats();
    setSource(2, 4, 4, 3, 1);
    pushPacket(2, srcSerial[2], 4, 3, 4);
    driveInputs();
    repeat (3) tick();
    checkEq("midrst_beats_before", 32'(beatCount - beatBase), 32'd2);
    checkEq("midrst_busy_before",  32'(busy), 32'd1);
    doReset("midrst");
    clearStats();
    setSource(0, 1, 1, 0, 1);
    setSource(3, 1, 1, 0, 1);
    pushPacket(0, srcSerial[0], 1, 0, 1);
    pushPacket(3, srcSerial[3], 1, 0, 1);
    driveInputs();
    applyStimulus("after_rst", 40);
    checkEq("after_rst_grants", 32'(grantIds.size()), 32'd2);
    if (grantIds.size() > 1) begin
      checkEq("after_rst_first",  32'(grantIds[0]), 32'd0);
      checkEq("after_rst_second", 32'(grantIds[1]), 32'd3);
    end
    checkEq("after_rst_err", 32'(errCount - errBase), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
